// File: rtl/i2s_rx_capture.sv
// I2S capture into an SDRAM ring buffer: oversampled codec pins -> stereo frame FIFO -> 16-bit word writer.
// Latency: 3 Clk50 from SClk pin edge to bit capture; a frame is popped the cycle after it lands in the FIFO.
// Backpressure: each write is held until sdram_ac; a full FIFO with no pop drops the frame and sets overflow.
module i2s_rx_capture #(
    parameter int          SAMPLE_BITS = 16,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [24:0] BASE_ADDR   = 25'h100000,
    parameter logic [24:0] BUF_WORDS   = 25'h040000
) (
    input  logic        Clk50,
    input  logic        reset_n,
    input  logic        SClk,
    input  logic        LRClk,
    input  logic        Din,
    input  logic        enable,
    input  logic        clear_ovf,
    output logic [24:0] sdram_addr,
    output logic        sdram_wr,
    output logic [15:0] sdram_data,
    output logic [1:0]  sdram_be,
    input  logic        sdram_ac,
    output logic [24:0] wr_ptr,
    output logic        overflow,
    output logic        busy
);
    localparam int          CW        = $clog2(SAMPLE_BITS + 1);
    localparam int          AW        = $clog2(FIFO_DEPTH);
    localparam logic [24:0] LAST_ADDR = BASE_ADDR + BUF_WORDS - 25'd1;

    typedef enum logic [1:0] {IDLE, WR_L, WR_R} wstate_t;

    logic [1:0]    sclk_sync_q, lr_sync_q, din_sync_q;
    logic          sclk_prev_q;
    logic          lr_last_q, word_ok_q, armed_q, ovf_q;
    logic [CW-1:0] bit_cnt_q;
    logic [15:0]   shift_q, left_q;
    logic [31:0]   fifo_mem_q [FIFO_DEPTH];
    logic [AW-1:0] fifo_wp_q, fifo_rp_q;
    logic [AW:0]   fifo_cnt_q;

    wstate_t       state_q, state_d;
    logic          wr_q, wr_d;
    logic [24:0]   addr_q, addr_d, ptr_q, ptr_d, next_ptr;
    logic [15:0]   data_q, data_d, rw_q, rw_d;
    logic [1:0]    be_q, be_d;

    logic          sclk_rise, lr_s, din_s, word_done, push_req, push, pop, drop;
    logic          fifo_full, fifo_empty;
    logic [15:0]   word;

    assign sclk_rise = sclk_sync_q[1] & ~sclk_prev_q;
    assign lr_s      = lr_sync_q[1];
    assign din_s     = din_sync_q[1];
    assign word      = {shift_q[14:0], din_s};
    assign word_done = sclk_rise && (lr_s == lr_last_q) && (bit_cnt_q == CW'(SAMPLE_BITS - 1));
    assign push_req  = word_done && lr_last_q && armed_q && enable;

    assign fifo_full  = (fifo_cnt_q == (AW + 1)'(FIFO_DEPTH));
    assign fifo_empty = (fifo_cnt_q == '0);
    assign pop        = (state_q == IDLE) && !fifo_empty;
    assign push       = push_req && (!fifo_full || pop);
    assign drop       = push_req && fifo_full && !pop;

    always_ff @(posedge Clk50 or negedge reset_n) begin
        if (!reset_n) begin
            sclk_sync_q <= '0;
            lr_sync_q   <= '0;
            din_sync_q  <= '0;
            sclk_prev_q <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[0], SClk};
            lr_sync_q   <= {lr_sync_q[0], LRClk};
            din_sync_q  <= {din_sync_q[0], Din};
            sclk_prev_q <= sclk_sync_q[1];
        end
    end

    // A left word may only arm capture if enable was already high at its delay slot,
    // so a word that was partly shifted before enable rose never starts a frame.
    always_ff @(posedge Clk50 or negedge reset_n) begin
        if (!reset_n) begin
            lr_last_q <= 1'b0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            left_q    <= '0;
            word_ok_q <= 1'b0;
            armed_q   <= 1'b0;
        end else begin
            if (sclk_rise) begin
                if (lr_s != lr_last_q) begin
                    lr_last_q <= lr_s;
                    bit_cnt_q <= '0;
                    if (!lr_s) word_ok_q <= enable;
                end else if (bit_cnt_q < CW'(SAMPLE_BITS)) begin
                    shift_q   <= word;
                    bit_cnt_q <= bit_cnt_q + CW'(1);
                end
            end
            if (word_done && !lr_last_q) left_q <= word;
            if (!enable) begin
                armed_q   <= 1'b0;
                word_ok_q <= 1'b0;
            end else if (word_done && !lr_last_q && word_ok_q) begin
                armed_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge Clk50) begin
        if (push) fifo_mem_q[fifo_wp_q] <= {left_q, word};
    end

    always_ff @(posedge Clk50 or negedge reset_n) begin
        if (!reset_n) begin
            fifo_wp_q  <= '0;
            fifo_rp_q  <= '0;
            fifo_cnt_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            if (push) fifo_wp_q <= fifo_wp_q + AW'(1);
            if (pop)  fifo_rp_q <= fifo_rp_q + AW'(1);
            if (push && !pop)      fifo_cnt_q <= fifo_cnt_q + (AW + 1)'(1);
            else if (pop && !push) fifo_cnt_q <= fifo_cnt_q - (AW + 1)'(1);
            if (drop)           ovf_q <= 1'b1;
            else if (clear_ovf) ovf_q <= 1'b0;
        end
    end

    assign next_ptr = (ptr_q == LAST_ADDR) ? BASE_ADDR : ptr_q + 25'd1;

    // WR_R spends its first cycle with wr low, giving the idle gap after the left word's ack.
    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        data_d  = data_q;
        be_d    = be_q;
        ptr_d   = ptr_q;
        rw_d    = rw_q;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    state_d = WR_L;
                    wr_d    = 1'b1;
                    addr_d  = ptr_q;
                    data_d  = fifo_mem_q[fifo_rp_q][31:16];
                    rw_d    = fifo_mem_q[fifo_rp_q][15:0];
                    be_d    = 2'b11;
                end
            end
            WR_L: begin
                if (sdram_ac) begin
                    wr_d    = 1'b0;
                    be_d    = 2'b00;
                    ptr_d   = next_ptr;
                    state_d = WR_R;
                end
            end
            WR_R: begin
                if (!wr_q) begin
                    wr_d   = 1'b1;
                    addr_d = ptr_q;
                    data_d = rw_q;
                    be_d   = 2'b11;
                end else if (sdram_ac) begin
                    wr_d    = 1'b0;
                    be_d    = 2'b00;
                    ptr_d   = next_ptr;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            wr_q    <= 1'b0;
            addr_q  <= BASE_ADDR;
            data_q  <= '0;
            be_q    <= 2'b00;
            ptr_q   <= BASE_ADDR;
            rw_q    <= '0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            be_q    <= be_d;
            ptr_q   <= ptr_d;
            rw_q    <= rw_d;
        end
    end

    assign sdram_wr   = wr_q;
    assign sdram_addr = addr_q;
    assign sdram_data = data_q;
    assign sdram_be   = be_q;
    assign wr_ptr     = ptr_q;
    assign overflow   = ovf_q;
    assign busy       = !fifo_empty || (state_q != IDLE);
endmodule
